// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: shared polynomial constants, FSM state type and bit-serial CRC helpers
// for the streaming CRC engine.
package crc_stream_pkg;

   localparam logic [31:0] CRC32_ETH   = 32'h04C1_1DB7;
   localparam logic [31:0] CRC16_CCITT = 32'h0000_1021;
   localparam logic [31:0] CRC8        = 32'h0000_0007;

   typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

   function automatic logic [31:0] width_mask(input int w);
      return 32'((33'd1 << w) - 33'd1);
   endfunction

   // Reverse the low w bits of v; bits above w come back as zero.
   function automatic logic [31:0] reflect(input logic [31:0] v, input int w);
      logic [31:0] r;
      logic [31:0] s;
      r = '0;
      s = v;
      for (int i = 0; i < 32; i++) begin
         if (i < w) begin
            r = {r[30:0], s[0]};
            s = s >> 1;
         end
      end
      return r;
   endfunction

   // One byte through a w-bit normal-form register, MSB of the byte first.
   function automatic logic [31:0] crc_byte_step(input logic [31:0] crc, input logic [7:0] b,
                                                 input logic [31:0] poly, input int w);
      logic [31:0] c;
      logic [7:0]  d;
      logic        fb;
      c = crc;
      d = b;
      for (int i = 0; i < 8; i++) begin
         fb = (|(c & (32'd1 << (w - 1)))) ^ d[7];
         c  = ((c << 1) ^ (fb ? poly : 32'd0)) & width_mask(w);
         d  = d << 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/crc_stream_lane_chain.sv
// crc_stream_lane_chain: combinational fold of one beat's enabled byte lanes into the CRC
// register, lane 0 first.
module crc_stream_lane_chain
   import crc_stream_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          CRC_WIDTH  = 32,
   parameter logic [31:0] POLY       = CRC32_ETH,
   parameter bit          REFLECT_IN = 1'b1
) (
   input  logic [CRC_WIDTH-1:0]    i_crc,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [DATA_WIDTH/8-1:0] i_keep,
   output logic [CRC_WIDTH-1:0]    o_crc
);

   localparam int          LANES = DATA_WIDTH / 8;
   localparam logic [31:0] P     = POLY & width_mask(CRC_WIDTH);

   logic [31:0]           w_acc;
   logic [31:0]           w_byte;
   logic [DATA_WIDTH-1:0] w_d;
   logic [LANES-1:0]      w_k;

   // Lanes are consumed by shifting so that each step only looks at the low byte.
   always_comb begin
      w_acc  = 32'(i_crc);
      w_byte = '0;
      w_d    = i_data;
      w_k    = i_keep;
      for (int k = 0; k < LANES; k++) begin
         w_byte = REFLECT_IN ? reflect(32'(w_d[7:0]), 8) : 32'(w_d[7:0]);
         w_acc  = w_k[0] ? crc_byte_step(w_acc, w_byte[7:0], P, CRC_WIDTH) : w_acc;
         w_d    = w_d >> 8;
         w_k    = w_k >> 1;
      end
   end

   assign o_crc = w_acc[CRC_WIDTH-1:0];

endmodule

// File: rtl/crc_stream.sv
// crc_stream: streaming CRC engine with byte enables and per-frame framing; each frame's
// CRC and residue flag are held in a single-entry valid/ready output slot.
module crc_stream
   import crc_stream_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          CRC_WIDTH   = 32,
   parameter logic [31:0] POLY        = CRC32_ETH,
   parameter logic [31:0] INIT        = 32'hFFFF_FFFF,
   parameter logic [31:0] XOR_OUT     = 32'hFFFF_FFFF,
   parameter bit          REFLECT_IN  = 1'b1,
   parameter bit          REFLECT_OUT = 1'b1,
   parameter logic [31:0] RESIDUE     = 32'h2144_DF1C
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    clear_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic [DATA_WIDTH-1:0]   s_data_i,
   input  logic [DATA_WIDTH/8-1:0] s_keep_i,
   input  logic                    s_last_i,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [CRC_WIDTH-1:0]    m_crc_o,
   output logic                    m_ok_o
);

   localparam int                   LANES     = DATA_WIDTH / 8;
   localparam logic [CRC_WIDTH-1:0] C_INIT    = INIT[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] C_XOR     = XOR_OUT[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] C_RESIDUE = RESIDUE[CRC_WIDTH-1:0];

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_rst_sync;
   logic [CRC_WIDTH-1:0]  r_crc;
   logic [CRC_WIDTH-1:0]  r_m_crc;
   logic                  r_m_ok;
   logic [CRC_WIDTH-1:0]  w_crc_nxt;
   logic [CRC_WIDTH-1:0]  w_crc_fin;
   logic [31:0]           w_refl;
   logic                  w_take;
   logic                  w_close;
   logic [LANES:0]        w_keep_p1;

   crc_stream_lane_chain #(
      .DATA_WIDTH (DATA_WIDTH),
      .CRC_WIDTH  (CRC_WIDTH),
      .POLY       (POLY),
      .REFLECT_IN (REFLECT_IN)
   ) u_chain (
      .i_crc  (r_crc),
      .i_data (s_data_i),
      .i_keep (s_keep_i),
      .o_crc  (w_crc_nxt)
   );

   assign w_refl    = reflect(32'(w_crc_nxt), CRC_WIDTH);
   assign w_crc_fin = (REFLECT_OUT ? w_refl[CRC_WIDTH-1:0] : w_crc_nxt) ^ C_XOR;

   // Input stays closed until reset release has crossed the synchroniser.
   assign s_ready_o = r_rst_sync[1] & ((r_state == ST_ACCUM) | m_ready_i);
   assign w_take    = s_valid_i & s_ready_o & ~clear_i;
   assign w_close   = w_take & s_last_i;
   assign m_valid_o = (r_state == ST_HOLD);
   assign m_crc_o   = r_m_crc;
   assign m_ok_o    = r_m_ok;

   always_comb begin
      w_state_nxt = w_close ? ST_HOLD : (r_state == ST_HOLD && m_ready_i) ? ST_ACCUM : r_state;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rst_sync <= '0;
         r_state    <= ST_ACCUM;
         r_crc      <= C_INIT;
         r_m_crc    <= '0;
         r_m_ok     <= 1'b0;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
         r_state    <= w_state_nxt;
         r_crc      <= (clear_i || w_close) ? C_INIT : w_take ? w_crc_nxt : r_crc;
         r_m_crc    <= w_close ? w_crc_fin : r_m_crc;
         r_m_ok     <= w_close ? (w_crc_fin == C_RESIDUE) : r_m_ok;
      end
   end

   // Byte enables must be a run of ones starting at lane 0.
   assign w_keep_p1 = {1'b0, s_keep_i} + (LANES + 1)'(1);

   a_keep_contig : assert property (@(posedge clk_i) disable iff (!rstn_i)
      (s_valid_i && s_ready_o) |-> (({1'b0, s_keep_i} & w_keep_p1) == '0));

endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: directed checks of the streaming CRC engine (CRC-32 default build and a
// CRC-16/CCITT byte-wide build) plus a randomised run against a reflected-table-free model.
module tb_crc_stream;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        clear = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic [3:0]  s_keep = '0;
   logic        s_last = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_crc;
   logic        m_ok;

   logic        s_valid16 = 1'b0;
   logic        s_ready16;
   logic [7:0]  s_data16 = '0;
   logic [0:0]  s_keep16 = '0;
   logic        s_last16 = 1'b0;
   logic        m_valid16;
   logic        m_ready16 = 1'b1;
   logic [15:0] m_crc16;
   logic        m_ok16;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  fq[$];
   logic [7:0]  msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   logic [31:0] got_crc;
   logic        got_ok;

   always #5 clk = ~clk;

   crc_stream u_dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .clear_i   (clear),
      .s_valid_i (s_valid),
      .s_ready_o (s_ready),
      .s_data_i  (s_data),
      .s_keep_i  (s_keep),
      .s_last_i  (s_last),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_crc_o   (m_crc),
      .m_ok_o    (m_ok)
   );

   crc_stream #(
      .DATA_WIDTH  (8),
      .CRC_WIDTH   (16),
      .POLY        (32'h1021),
      .INIT        (32'hFFFF),
      .XOR_OUT     (32'h0),
      .REFLECT_IN  (1'b0),
      .REFLECT_OUT (1'b0),
      .RESIDUE     (32'h0)
   ) u_dut16 (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .clear_i   (1'b0),
      .s_valid_i (s_valid16),
      .s_ready_o (s_ready16),
      .s_data_i  (s_data16),
      .s_keep_i  (s_keep16),
      .s_last_i  (s_last16),
      .m_valid_o (m_valid16),
      .m_ready_i (m_ready16),
      .m_crc_o   (m_crc16),
      .m_ok_o    (m_ok16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called and returns one time unit after a rising edge; returns after the accepting edge.
   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      #1;
      while (!s_ready && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic recv(input int delay, output logic [31:0] crc, output logic ok);
      int n;
      n = 0;
      repeat (delay) tick();
      m_ready = 1'b1;
      while (!m_valid && n < 50) begin
         tick();
         n++;
      end
      chk("recv_valid", 32'(m_valid), 32'd1);
      crc = m_crc;
      ok  = m_ok;
      tick();
      m_ready = 1'b0;
   endtask

   task automatic send_frame(input int gap);
      int          n;
      int          i;
      logic [31:0] d;
      logic [3:0]  k;
      n = fq.size();
      i = 0;
      if (n == 0) send(32'h0, 4'h0, 1'b1);
      while (i < n) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 4; j++) begin
            if (i + j < n) begin
               d = d | (32'(fq[i+j]) << (8 * j));
               k = k | (4'd1 << j);
            end
         end
         i += 4;
         repeat ($urandom_range(gap)) tick();
         send(d, k, i >= n);
      end
   endtask

   function automatic logic [31:0] crc32_ref();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (fq[i]) begin
         c = c ^ 32'(fq[i]);
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic load_msg();
      fq.delete();
      foreach (msg[i]) fq.push_back(msg[i]);
   endtask

   initial begin
      logic [31:0] exp;
      logic [31:0] c;
      logic        fcs;

      repeat (3) tick();
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_crc", m_crc, 32'h0);
      chk("rst_m_ok", 32'(m_ok), 32'd0);
      rstn = 1'b1;
      repeat (3) tick();
      chk("rel_s_ready", 32'(s_ready), 32'd1);

      // "123456789" in three beats; result one cycle after the last beat, then held.
      send(32'h3433_3231, 4'hF, 1'b0);
      send(32'h3837_3635, 4'hF, 1'b0);
      send(32'h0000_0039, 4'h1, 1'b1);
      chk("check_latency", 32'(m_valid), 32'd1);
      chk("check_crc", m_crc, 32'hCBF4_3926);
      chk("check_ok", 32'(m_ok), 32'd0);
      repeat (3) tick();
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_crc", m_crc, 32'hCBF4_3926);
      recv(0, got_crc, got_ok);
      chk("drain_valid", 32'(m_valid), 32'd0);

      // Same bytes followed by the little-endian FCS must land on the residue.
      send(32'h3433_3231, 4'hF, 1'b0);
      send(32'h3837_3635, 4'hF, 1'b0);
      send(32'hF439_2639, 4'hF, 1'b0);
      send(32'h0000_00CB, 4'h1, 1'b1);
      recv(1, got_crc, got_ok);
      chk("fcs_crc", got_crc, 32'h2144_DF1C);
      chk("fcs_ok", 32'(got_ok), 32'd1);

      // Partial keep on non-last beats with junk in the disabled lanes.
      send(32'hDEAD_3231, 4'h3, 1'b0);
      send(32'h3635_3433, 4'hF, 1'b0);
      send(32'hAA39_3837, 4'h7, 1'b1);
      recv(0, got_crc, got_ok);
      chk("partial_keep_crc", got_crc, 32'hCBF4_3926);

      // Closing with an empty last beat after data.
      send(32'h3433_3231, 4'hF, 1'b0);
      send(32'h3837_3635, 4'hF, 1'b0);
      send(32'hFFFF_FF39, 4'h1, 1'b0);
      send(32'h1234_5678, 4'h0, 1'b1);
      recv(0, got_crc, got_ok);
      chk("empty_last_crc", got_crc, 32'hCBF4_3926);

      // Back-to-back: second frame (empty) stalls while the first result is held.
      load_msg();
      send_frame(0);
      s_valid = 1'b1;
      s_data  = 32'h0;
      s_keep  = 4'h0;
      s_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_s_ready", 32'(s_ready), 32'd0);
         tick();
      end
      chk("stall_first_crc", m_crc, 32'hCBF4_3926);
      m_ready = 1'b1;
      #1;
      chk("swap_s_ready", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      chk("swap_valid", 32'(m_valid), 32'd1);
      chk("swap_empty_crc", m_crc, 32'h0);
      chk("swap_empty_ok", 32'(m_ok), 32'd0);
      tick();
      m_ready = 1'b0;
      chk("swap_drained", 32'(m_valid), 32'd0);

      // Clear mid-frame discards the frame and the same-cycle last beat.
      send(32'h1122_3344, 4'hF, 1'b0);
      clear   = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'hAAAA_AAAA;
      s_keep  = 4'hF;
      s_last  = 1'b1;
      tick();
      clear   = 1'b0;
      s_valid = 1'b0;
      chk("clear_no_result", 32'(m_valid), 32'd0);
      load_msg();
      send_frame(0);
      chk("clear_crc", m_crc, 32'hCBF4_3926);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_hold_valid", 32'(m_valid), 32'd1);
      chk("clear_hold_crc", m_crc, 32'hCBF4_3926);
      recv(0, got_crc, got_ok);

      // Reset in the middle of a frame: nothing emitted, engine restarts from INIT.
      send(32'h3433_3231, 4'hF, 1'b0);
      rstn = 1'b0;
      #1;
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      tick();
      rstn = 1'b1;
      repeat (4) tick();
      chk("midrst_no_result", 32'(m_valid), 32'd0);
      load_msg();
      send_frame(0);
      recv(0, got_crc, got_ok);
      chk("midrst_crc", got_crc, 32'hCBF4_3926);

      // Byte-wide CRC-16/CCITT build, streamed with the output always ready.
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 11; i++) begin
            if (f == 1 || i < 9) begin
               s_data16  = (i < 9) ? msg[i] : (i == 9) ? 8'h29 : 8'hB1;
               s_keep16  = 1'b1;
               s_last16  = (i == (f == 1 ? 10 : 8));
               s_valid16 = 1'b1;
               #1;
               chk("c16_ready", 32'(s_ready16), 32'd1);
               tick();
            end
         end
         s_valid16 = 1'b0;
         chk("c16_valid", 32'(m_valid16), 32'd1);
         chk("c16_crc", 32'(m_crc16), (f == 1) ? 32'h0 : 32'h29B1);
         chk("c16_ok", 32'(m_ok16), 32'(f == 1));
      end

      // Randomised frames with input gaps and output back-pressure against the model.
      for (int f = 0; f < 200; f++) begin
         fq.delete();
         repeat ($urandom_range(12)) fq.push_back(8'($urandom));
         fcs = $urandom_range(1);
         c = crc32_ref();
         if (fcs) begin
            fq.push_back(c[7:0]);
            fq.push_back(c[15:8]);
            fq.push_back(c[23:16]);
            fq.push_back(c[31:24]);
         end
         exp = fcs ? 32'h2144_DF1C : c;
         send_frame(2);
         recv($urandom_range(3), got_crc, got_ok);
         chk("rnd_crc", got_crc, exp);
         chk("rnd_ok", 32'(got_ok), 32'(exp == 32'h2144_DF1C));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
